pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core: PC, xREG1 (IF/ID), xREG2 (ID/EX), xREG3 (EX/MEM), xREG4 (MEM/WB).
- Takes the load-use hazard flag from the forwarding unit, the taken-branch flag from EX, and memory ready handshakes.
- Produces per-stage load enables and bubble-insert (flush) controls, and implements a debug halt/drain sequence and a data-memory wait timeout.

---
 rtl/pipe_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage pipeline (PC, xREG1..xREG4).
//
// Combines the load-use hazard, taken-branch and memory handshakes into per-stage
// load enables and bubble-insert controls. Also runs a debug halt/drain sequence
// and forces release of a data-memory wait that exceeds DM_TIMEOUT cycles.
//
// Parameters:
//   DM_TIMEOUT   (2..255) cycles in DM_WAIT before forced release
//   DRAIN_CYCLES (1..7)   bubble-injection cycles in HALTING before HALTED
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   do_hazard                load-use hazard from the forwarding unit
//   do_branch                taken branch/jump resolved at xREG2 output
//   im_ready                 instruction memory delivers the fetch word
//   dm_req, dm_ready         data-memory access in xREG3 / completion
//   halt_req                 debug halt request (level)
//   pc_en, xREG1..4_en       stage load enables
//   xREG1_flush, xREG2_flush load a NOP bubble (only meaningful with _en=1)
//   halted                   pipeline drained and stopped
//   dm_timeout               one-cycle pulse on a forced DM_WAIT release
//
// Optional build macro PIPE_CTRL_PERF_EN adds perf_clr (sync clear) and the
// 32-bit stall_cycles counter (cycles with pc_en=0 outside HALTED).

module pipe_ctrl #(
  parameter int unsigned DM_TIMEOUT   = 16,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        do_hazard,
  input  logic        do_branch,
  input  logic        im_ready,
  input  logic        dm_req,
  input  logic        dm_ready,
  input  logic        halt_req,
`ifdef PIPE_CTRL_PERF_EN
  input  logic        perf_clr,
  output logic [31:0] stall_cycles,
`endif
  output logic        pc_en,
  output logic        xREG1_en,
  output logic        xREG2_en,
  output logic        xREG3_en,
  output logic        xREG4_en,
  output logic        xREG1_flush,
  output logic        xREG2_flush,
  output logic        halted,
  output logic        dm_timeout
);

  typedef enum logic [1:0] {StRun, StDmWait, StHalting, StHalted} state_e;

  localparam logic [7:0] WaitLast  = 8'(DM_TIMEOUT - 1);
  localparam logic [2:0] DrainLast = 3'(DRAIN_CYCLES - 1);

  state_e     state_q, state_d;
  logic       ret_halt_q, ret_halt_d;  // DM_WAIT returns to HALTING when set
  logic       kill_fetch_q, kill_fetch_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [2:0] drain_cnt_q, drain_cnt_d;

  logic   wait_expired;
  logic   dm_release;
  logic   freeze;
  state_e eff_state;

  assign wait_expired = (wait_cnt_q == WaitLast);
  assign dm_release   = (state_q == StDmWait) && (dm_ready || wait_expired);
  assign freeze       = ((state_q == StRun) || (state_q == StHalting)) && dm_req && !dm_ready;

  // On the release cycle the block behaves as the saved state with the freeze lifted.
  always_comb begin
    eff_state = state_q;
    if (dm_release) begin
      eff_state = ret_halt_q ? StHalting : StRun;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRun;
      ret_halt_q   <= 1'b0;
      kill_fetch_q <= 1'b0;
      wait_cnt_q   <= 8'd0;
      drain_cnt_q  <= 3'd0;
    end else begin
      state_q      <= state_d;
      ret_halt_q   <= ret_halt_d;
      kill_fetch_q <= kill_fetch_d;
      wait_cnt_q   <= wait_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    ret_halt_d   = ret_halt_q;
    kill_fetch_d = kill_fetch_q;
    wait_cnt_d   = wait_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    if (dm_release) begin
      wait_cnt_d = 8'd0;
    end
    unique case (eff_state)
      StRun: begin
        if (freeze) begin
          state_d    = StDmWait;
          ret_halt_d = 1'b0;
        end else begin
          if (do_branch) begin
            // Fetch in flight is from the wrong path; drop it when it lands.
            if (!im_ready) kill_fetch_d = 1'b1;
          end else if (!do_hazard && im_ready && kill_fetch_q) begin
            kill_fetch_d = 1'b0;
          end
          if (halt_req) begin
            state_d     = StHalting;
            drain_cnt_d = 3'd0;
          end else begin
            state_d = StRun;
          end
        end
      end
      StHalting: begin
        if (freeze) begin
          state_d    = StDmWait;
          ret_halt_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 3'd1;
          if (!halt_req) begin
            state_d = StRun;
          end else if (drain_cnt_q == DrainLast) begin
            state_d = StHalted;
          end else begin
            state_d = StHalting;
          end
        end
      end
      StDmWait: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
      StHalted: begin
        if (!halt_req) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // Output decode
  always_comb begin
    pc_en       = 1'b0;
    xREG1_en    = 1'b0;
    xREG2_en    = 1'b0;
    xREG3_en    = 1'b0;
    xREG4_en    = 1'b0;
    xREG1_flush = 1'b0;
    xREG2_flush = 1'b0;
    halted      = (state_q == StHalted);
    dm_timeout  = (state_q == StDmWait) && !dm_ready && wait_expired;
    unique case (eff_state)
      StRun: begin
        if (!freeze) begin
          pc_en    = 1'b1;
          xREG1_en = 1'b1;
          xREG2_en = 1'b1;
          xREG3_en = 1'b1;
          xREG4_en = 1'b1;
          if (do_branch) begin
            xREG1_flush = 1'b1;
            xREG2_flush = 1'b1;
          end else begin
            if (do_hazard) begin
              pc_en       = 1'b0;
              xREG1_en    = 1'b0;
              xREG2_flush = 1'b1;
            end
            if (!im_ready) begin
              pc_en = 1'b0;
              // xREG1 is already held by a hazard; only bubble it when it loads.
              if (!do_hazard) xREG1_flush = 1'b1;
            end
            if (!do_hazard && im_ready && kill_fetch_q) begin
              xREG1_flush = 1'b1;
            end
          end
        end
      end
      StHalting: begin
        if (!freeze) begin
          xREG1_en    = 1'b1;
          xREG2_en    = 1'b1;
          xREG3_en    = 1'b1;
          xREG4_en    = 1'b1;
          xREG1_flush = 1'b1;
          if (do_branch) begin
            // Let the PC capture the branch target before the pipe stops.
            pc_en       = 1'b1;
            xREG2_flush = 1'b1;
          end
        end
      end
      StDmWait, StHalted: begin
      end
      default: begin
      end
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = 32'd0;
    end else if (!pc_en && (state_q != StHalted)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Outputs are compared as a 9-bit vector
// {pc_en, xREG1_en..xREG4_en, xREG1_flush, xREG2_flush, halted, dm_timeout}.
// dut uses default parameters; dut_to uses DM_TIMEOUT=4 for the timeout case.

module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic do_hazard, do_branch, im_ready, dm_req, dm_ready, halt_req;

  logic pc_en, e1, e2, e3, e4, f1, f2, hlt, tmo;
  logic t_pc_en, t_e1, t_e2, t_e3, t_e4, t_f1, t_f2, t_hlt, t_tmo;

  always #5 clk = ~clk;

  pipe_ctrl #(.DM_TIMEOUT(16), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .do_hazard(do_hazard), .do_branch(do_branch), .im_ready(im_ready),
    .dm_req(dm_req), .dm_ready(dm_ready), .halt_req(halt_req),
    .pc_en(pc_en), .xREG1_en(e1), .xREG2_en(e2), .xREG3_en(e3), .xREG4_en(e4),
    .xREG1_flush(f1), .xREG2_flush(f2), .halted(hlt), .dm_timeout(tmo)
  );

  pipe_ctrl #(.DM_TIMEOUT(4), .DRAIN_CYCLES(3)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .do_hazard(do_hazard), .do_branch(do_branch), .im_ready(im_ready),
    .dm_req(dm_req), .dm_ready(dm_ready), .halt_req(halt_req),
    .pc_en(t_pc_en), .xREG1_en(t_e1), .xREG2_en(t_e2), .xREG3_en(t_e3), .xREG4_en(t_e4),
    .xREG1_flush(t_f1), .xREG2_flush(t_f2), .halted(t_hlt), .dm_timeout(t_tmo)
  );

  // Expected output patterns
  localparam logic [8:0] E_ALL  = 9'b111110000;
  localparam logic [8:0] E_ZERO = 9'b000000000;
  localparam logic [8:0] E_LU   = 9'b001110100;  // load-use stall
  localparam logic [8:0] E_BR   = 9'b111111100;  // branch: both bubbles, PC loads
  localparam logic [8:0] E_MISS = 9'b011111000;  // fetch miss / halting drain
  localparam logic [8:0] E_KILL = 9'b111111000;  // wrong-path word discarded
  localparam logic [8:0] E_HLTD = 9'b000000010;
  localparam logic [8:0] E_TOUT = 9'b111110001;  // forced release, decodes as RUN

  // Input pattern {do_hazard, do_branch, im_ready, dm_req, dm_ready, halt_req}
  typedef struct {
    string      name;
    logic [5:0] in;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [8:0] dut_out();
    return {pc_en, e1, e2, e3, e4, f1, f2, hlt, tmo};
  endfunction

  function automatic logic [8:0] to_out();
    return {t_pc_en, t_e1, t_e2, t_e3, t_e4, t_f1, t_f2, t_hlt, t_tmo};
  endfunction

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] in);
    {do_hazard, do_branch, im_ready, dm_req, dm_ready, halt_req} = in;
  endtask

  task automatic add(input string nm, input logic [5:0] in, input logic [8:0] exp);
    vec_t v;
    v.name = nm;
    v.in   = in;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  // Called at posedge+1; samples mid-cycle, then advances one clock.
  task automatic step_check(input string nm, input logic [5:0] in, input logic [8:0] exp);
    drive(in);
    #2;
    check(nm, dut_out(), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    add("idle",        6'b001000, E_ALL);
    add("load_use",    6'b101000, E_LU);
    add("after_lu",    6'b001000, E_ALL);
    add("br_hz_miss",  6'b110000, E_BR);
    add("kf_miss1",    6'b000000, E_MISS);
    add("kf_miss2",    6'b000000, E_MISS);
    add("kf_discard",  6'b001000, E_KILL);
    add("kf_clean",    6'b001000, E_ALL);
    add("dm_freeze",   6'b001100, E_ZERO);
    add("dm_wait1",    6'b001100, E_ZERO);
    add("dm_wait_ign", 6'b111100, E_ZERO);
    add("dm_wait3",    6'b001100, E_ZERO);
    add("dm_wait4",    6'b001100, E_ZERO);
    add("dm_ready",    6'b001110, E_ALL);
    add("post_dm",     6'b001000, E_ALL);
    add("halt_req",    6'b001001, E_ALL);
    add("drain0",      6'b001001, E_MISS);
    add("drain1",      6'b001001, E_MISS);
    add("drain2",      6'b001001, E_MISS);
    add("halted",      6'b001001, E_HLTD);
    add("halt_drop",   6'b001000, E_HLTD);
    add("resume",      6'b001000, E_ALL);
    add("halt2_req",   6'b001001, E_ALL);
    add("halt2_d0",    6'b001001, E_MISS);
    add("halt2_abort", 6'b001000, E_MISS);
    add("halt2_run",   6'b001000, E_ALL);
    add("halt3_req",   6'b001001, E_ALL);
    add("halt_branch", 6'b011001, E_BR);
    add("halt3_abort", 6'b001000, E_MISS);
    add("halt3_run",   6'b001000, E_ALL);
    add("halt4_req",   6'b001001, E_ALL);
    add("halt_freeze", 6'b001101, E_ZERO);
    add("halt_dmwait", 6'b001101, E_ZERO);
    add("halt_dmrdy",  6'b001111, E_MISS);
    add("halt4_d1",    6'b001001, E_MISS);
    add("halt4_d2",    6'b001001, E_MISS);
    add("halted4",     6'b001001, E_HLTD);
    add("halt4_drop",  6'b001000, E_HLTD);
    add("resume4",     6'b001000, E_ALL);
    add("im_miss",     6'b000000, E_MISS);
    add("im_back",     6'b001000, E_ALL);

    // Reset state
    rst_n = 1'b0;
    drive(6'b001000);
    #2;
    check("reset_dut", dut_out(), E_ALL);
    check("reset_dut_to", to_out(), E_ALL);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step_check(vecs[i].name, vecs[i].in, vecs[i].exp);
    end

    // Async reset while parked in DM_WAIT
    step_check("rst_frz", 6'b001100, E_ZERO);
    step_check("rst_wait0", 6'b001100, E_ZERO);
    step_check("rst_wait1", 6'b001100, E_ZERO);
    #1;
    rst_n = 1'b0;
    drive(6'b001000);
    #1;
    check("rst_mid_wait", dut_out(), E_ALL);
    check("rst_mid_wait_to", to_out(), E_ALL);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Forced release on the 4th DM_WAIT cycle (DM_TIMEOUT=4); wait_cnt starts from 0
    for (int k = 0; k < 5; k++) begin
      drive(6'b001100);
      #2;
      check($sformatf("timeout_c%0d", k), to_out(), (k == 4) ? E_TOUT : E_ZERO);
      @(posedge clk);
      #1;
    end
    drive(6'b001000);
    #2;
    check("timeout_back_run", to_out(), E_ALL);
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
